ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter RD_LAT, default 2, SHALL set the cycles from grant to read-data valid (legal 1..4).
REQ-002 Parameter AW, default 16, SHALL set the address width.
REQ-003 Parameter DW, default 16, SHALL set the data width.
REQ-004 clock  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-006 req0/we0  in  1/1  SHALL be the port-0 (core) access request and the write-not-read flag.
REQ-007 addr0/wdata0  in  AW/DW  SHALL be the port-0 address and write data.
REQ-008 gnt0  out  1  SHALL be the port-0 grant; the access is accepted in a cycle where req0 and gnt0 are both high.
REQ-009 rvalid0/rdata0  out  1/DW  SHALL be the port-0 read-return strobe and data.
REQ-010 req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1, same widths, SHALL form port 1 (host/debug) with identical semantics.
REQ-011 lock1  in  1  SHALL be the port-1 bus-lock request.
REQ-012 address_ram/data_ram/wren_ram  out  AW/DW/1  SHALL drive the single-port RAM.
REQ-013 q_ram  in  DW  SHALL be the RAM read data.
REQ-014 busy  out  1  SHALL be high while any read is in flight.

Function
REQ-015 At most one access SHALL be granted per cycle.
REQ-016 gnt0/gnt1 SHALL be combinational from req0, req1, lock state and the priority pointer; grant is never given to a port whose req is low.
REQ-017 With both requesting and no lock, the port not granted most recently SHALL win (round robin); after reset port 0 wins.
REQ-018 A granted access SHALL be registered onto address_ram/data_ram/wren_ram at the edge ending the grant cycle and held for exactly one cycle.
REQ-019 In any cycle with no access issued, wren_ram SHALL be 0; address_ram and data_ram SHALL hold their last values.
REQ-020 A granted read SHALL raise the owner's rvalid for exactly one cycle, RD_LAT cycles after the grant cycle, with rdataN = q_ram in that cycle.
REQ-021 In-flight reads SHALL be tracked by an RD_LAT-deep valid/owner shift register, so back-to-back reads from either port return in issue order with no bubbles.
REQ-022 A granted write SHALL produce no rvalid.
REQ-023 rdata of the non-returning port SHALL hold its previous value.
REQ-024 Lock: a port-1 grant with lock1 high SHALL enter LOCKED; in LOCKED only port 1 is granted.
REQ-025 LOCKED SHALL exit in the first cycle lock1 is low; port 0 then has priority for the next contended cycle.
REQ-026 Lock SHALL take effect only on a granted port-1 access; lock1 without req1 has no effect.
REQ-027 busy SHALL equal the OR of the in-flight valid bits.
REQ-028 States SHALL be IDLE_RR (normal round robin) and LOCKED; the only transitions are IDLE_RR->LOCKED per REQ-024 and LOCKED->IDLE_RR per REQ-025.

Reset
REQ-029 While reset_n is low: gnt0=gnt1=0, wren_ram=0, address_ram=0, data_ram=0, rvalid0=rvalid1=0, rdata0=rdata1=0, busy=0, state=IDLE_RR, pointer=port 0.
REQ-030 Reads in flight when reset asserts SHALL be discarded; no rvalid SHALL follow reset release for them.
REQ-031 Reset SHALL take effect asynchronously; release SHALL be sampled synchronously, and the first grant is possible in the first cycle after release.

Verification
REQ-032 Single read: port0 reads 0x0010 at T, RAM holds 0xBEEF -> wren_ram=0 and address_ram=0x0010 at T+1, rvalid0=1 and rdata0=0xBEEF at T+2.
REQ-033 Contention: req0 and req1 held high 4 cycles after reset -> grants alternate 0,1,0,1; wren_ram=0 in every idle cycle.
REQ-034 Pipelined reads: port0 0x1, port1 0x2, port0 0x3 on consecutive cycles -> rvalid0, rvalid1, rvalid0 on consecutive cycles with matching data.
REQ-035 Lock: port1 writes 0x0005<-0x1234 with lock1=1, req0 high -> gnt0=0 until lock1 drops; a later read of 0x0005 returns 0x1234.
REQ-036 Reset mid-read: reset_n low one cycle after a read grant -> no rvalid, wren_ram=0, address_ram=0 after release.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// One requester port of the RAM arbiter.
// Carries the request/grant handshake, the write data and the read return.
interface ram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// Round-robin grant, port-1 bus lock, in-order pipelined read return.
module ram_arbiter #(
  parameter int RD_LAT = 2,
  parameter int AW     = 16,
  parameter int DW     = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  ram_arbiter_if.slave  p0,
  ram_arbiter_if.slave  p1,
  input  logic          lock1,
  output logic [AW-1:0] address_ram,
  output logic [DW-1:0] data_ram,
  output logic          wren_ram,
  input  logic [DW-1:0] q_ram,
  output logic          busy
);

  typedef enum logic {
    IDLE_RR,
    LOCKED
  } state_t;

  state_t state;
  logic   ptr;

  logic          lock_act;
  logic          prio1;
  logic          g0;
  logic          g1;
  logic          issue;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  logic [RD_LAT-1:0] vld;
  logic [RD_LAT-1:0] own;
  logic              rv0;
  logic              rv1;
  logic [DW-1:0]     rdata_q0;
  logic [DW-1:0]     rdata_q1;

  // The lock-release cycle arbitrates as if port 0 held the pointer.
  always_comb begin
    lock_act  = (state == LOCKED) && lock1;
    prio1     = ptr && (state == IDLE_RR);
    g1        = reset_n && p1.req
              && (lock_act || !p0.req || prio1);
    g0        = reset_n && p0.req && !lock_act
              && (!p1.req || !prio1);
    issue     = g0 || g1;
    sel_we    = g1 ? p1.we    : p0.we;
    sel_addr  = g1 ? p1.addr  : p0.addr;
    sel_wdata = g1 ? p1.wdata : p0.wdata;
  end

  assign p0.gnt = g0;
  assign p1.gnt = g1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE_RR;
      ptr   <= 1'b0;
    end else begin
      if (g0)
        ptr <= 1'b1;
      else if (g1)
        ptr <= 1'b0;
      unique case (state)
        IDLE_RR:
          if (g1 && lock1)
            state <= LOCKED;
        LOCKED:
          if (!lock1)
            state <= IDLE_RR;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      address_ram <= '0;
      data_ram    <= '0;
      wren_ram    <= 1'b0;
    end else begin
      wren_ram <= issue && sel_we;
      if (issue) begin
        address_ram <= sel_addr;
        data_ram    <= sel_wdata;
      end
    end
  end

  // own marks port 1 as the owner of each in-flight read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
      own <= '0;
    end else begin
      vld[0] <= issue && !sel_we;
      own[0] <= g1;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        own[i] <= own[i-1];
      end
    end
  end

  assign rv0  = vld[RD_LAT-1] && !own[RD_LAT-1];
  assign rv1  = vld[RD_LAT-1] &&  own[RD_LAT-1];
  assign busy = |vld;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q0 <= '0;
      rdata_q1 <= '0;
    end else begin
      if (rv0)
        rdata_q0 <= q_ram;
      if (rv1)
        rdata_q1 <= q_ram;
    end
  end

  assign p0.rvalid = rv0;
  assign p1.rvalid = rv1;
  assign p0.rdata  = rv0 ? q_ram : rdata_q0;
  assign p1.rdata  = rv1 ? q_ram : rdata_q1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous RAM.
// Cycle table plus a hand-written reset-during-read sequence.
module tb_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        lock1 = 1'b0;
  logic [15:0] address_ram;
  logic [15:0] data_ram;
  logic        wren_ram;
  logic [15:0] q_ram = '0;
  logic        busy;

  ram_arbiter_if #(.AW(16), .DW(16)) b0 ();
  ram_arbiter_if #(.AW(16), .DW(16)) b1 ();

  ram_arbiter #(.RD_LAT(2), .AW(16), .DW(16)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .p0          (b0),
    .p1          (b1),
    .lock1       (lock1),
    .address_ram (address_ram),
    .data_ram    (data_ram),
    .wren_ram    (wren_ram),
    .q_ram       (q_ram),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [256];

  always @(posedge clock) begin
    if (wren_ram)
      mem[address_ram[7:0]] <= data_ram;
    q_ram <= mem[address_ram[7:0]];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       nm;
    logic        r0, w0;
    logic [15:0] a0, d0;
    logic        r1, w1;
    logic [15:0] a1, d1;
    logic        lk;
    logic        g0, g1, wr;
    logic [15:0] ar;
    logic        v0, v1;
    logic [15:0] q0, q1;
    logic        bz;
  } vec_t;

  function automatic vec_t mk(
    string nm,
    int r0, int w0, int a0, int d0,
    int r1, int w1, int a1, int d1, int lk,
    int g0, int g1, int wr, int ar,
    int v0, int v1, int q0, int q1, int bz);
    vec_t v;
    v.nm = nm;
    v.r0 = 1'(r0); v.w0 = 1'(w0);
    v.a0 = 16'(a0); v.d0 = 16'(d0);
    v.r1 = 1'(r1); v.w1 = 1'(w1);
    v.a1 = 16'(a1); v.d1 = 16'(d1);
    v.lk = 1'(lk);
    v.g0 = 1'(g0); v.g1 = 1'(g1); v.wr = 1'(wr);
    v.ar = 16'(ar);
    v.v0 = 1'(v0); v.v1 = 1'(v1);
    v.q0 = 16'(q0); v.q1 = 16'(q1);
    v.bz = 1'(bz);
    return v;
  endfunction

  task automatic drive(vec_t v);
    b0.req = v.r0; b0.we = v.w0; b0.addr = v.a0; b0.wdata = v.d0;
    b1.req = v.r1; b1.we = v.w1; b1.addr = v.a1; b1.wdata = v.d1;
    lock1 = v.lk;
  endtask

  task automatic run_vec(vec_t v);
    @(negedge clock);
    drive(v);
    #1;
    chk({v.nm, ".gnt0"},    16'(b0.gnt),    16'(v.g0));
    chk({v.nm, ".gnt1"},    16'(b1.gnt),    16'(v.g1));
    chk({v.nm, ".wren"},    16'(wren_ram),  16'(v.wr));
    chk({v.nm, ".addr"},    address_ram,    v.ar);
    chk({v.nm, ".rvalid0"}, 16'(b0.rvalid), 16'(v.v0));
    chk({v.nm, ".rvalid1"}, 16'(b1.rvalid), 16'(v.v1));
    chk({v.nm, ".rdata0"},  b0.rdata,       v.q0);
    chk({v.nm, ".rdata1"},  b1.rdata,       v.q1);
    chk({v.nm, ".busy"},    16'(busy),      16'(v.bz));
  endtask

  vec_t tbl[$];

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = 16'h1000 + 16'(i);
    mem[8'h10] = 16'hBEEF;

    //          name      r0 w0 a0    d0       r1 w1 a1    d1       lk g0 g1 wr ar     v0 v1 q0       q1       bz
    tbl.push_back(mk("cont0",  1,1,'h30,'hAAAA, 1,1,'h31,'hBBBB, 0, 1,0,0,'h0,  0,0,'h0,   'h0,   0));
    tbl.push_back(mk("cont1",  1,1,'h30,'hAAAA, 1,1,'h31,'hBBBB, 0, 0,1,1,'h30, 0,0,'h0,   'h0,   0));
    tbl.push_back(mk("cont2",  1,1,'h30,'hAAAA, 1,1,'h31,'hBBBB, 0, 1,0,1,'h31, 0,0,'h0,   'h0,   0));
    tbl.push_back(mk("cont3",  1,1,'h30,'hAAAA, 1,1,'h31,'hBBBB, 0, 0,1,1,'h30, 0,0,'h0,   'h0,   0));
    tbl.push_back(mk("idle4",  0,0,0,0,         0,0,0,0,         0, 0,0,1,'h31, 0,0,'h0,   'h0,   0));
    tbl.push_back(mk("idle5",  0,0,0,0,         0,0,0,0,         0, 0,0,0,'h31, 0,0,'h0,   'h0,   0));
    tbl.push_back(mk("pipe0",  1,0,'h1,0,       0,0,0,0,         0, 1,0,0,'h31, 0,0,'h0,   'h0,   0));
    tbl.push_back(mk("pipe1",  0,0,0,0,         1,0,'h2,0,       0, 0,1,0,'h1,  0,0,'h0,   'h0,   1));
    tbl.push_back(mk("pipe2",  1,0,'h3,0,       0,0,0,0,         0, 1,0,0,'h2,  1,0,'h1001,'h0,   1));
    tbl.push_back(mk("pipe3",  0,0,0,0,         0,0,0,0,         0, 0,0,0,'h3,  0,1,'h1001,'h1002,1));
    tbl.push_back(mk("pipe4",  0,0,0,0,         0,0,0,0,         0, 0,0,0,'h3,  1,0,'h1003,'h1002,1));
    tbl.push_back(mk("pipe5",  0,0,0,0,         0,0,0,0,         0, 0,0,0,'h3,  0,0,'h1003,'h1002,0));
    tbl.push_back(mk("sgl0",   1,0,'h10,0,      0,0,0,0,         0, 1,0,0,'h3,  0,0,'h1003,'h1002,0));
    tbl.push_back(mk("sgl1",   0,0,0,0,         0,0,0,0,         0, 0,0,0,'h10, 0,0,'h1003,'h1002,1));
    tbl.push_back(mk("sgl2",   0,0,0,0,         0,0,0,0,         0, 0,0,0,'h10, 1,0,'hBEEF,'h1002,1));
    tbl.push_back(mk("sgl3",   0,0,0,0,         0,0,0,0,         0, 0,0,0,'h10, 0,0,'hBEEF,'h1002,0));
    tbl.push_back(mk("rr0",    1,0,'h30,0,      1,0,'h31,0,      0, 0,1,0,'h10, 0,0,'hBEEF,'h1002,0));
    tbl.push_back(mk("rr1",    1,0,'h30,0,      0,0,0,0,         0, 1,0,0,'h31, 0,0,'hBEEF,'h1002,1));
    tbl.push_back(mk("rr2",    0,0,0,0,         0,0,0,0,         0, 0,0,0,'h30, 0,1,'hBEEF,'hBBBB,1));
    tbl.push_back(mk("rr3",    0,0,0,0,         0,0,0,0,         0, 0,0,0,'h30, 1,0,'hAAAA,'hBBBB,1));
    tbl.push_back(mk("rr4",    0,0,0,0,         0,0,0,0,         0, 0,0,0,'h30, 0,0,'hAAAA,'hBBBB,0));
    tbl.push_back(mk("lock0",  1,0,'h40,0,      1,1,'h5,'h1234,  1, 0,1,0,'h30, 0,0,'hAAAA,'hBBBB,0));
    tbl.push_back(mk("lock1",  1,0,'h40,0,      0,0,0,0,         1, 0,0,1,'h5,  0,0,'hAAAA,'hBBBB,0));
    tbl.push_back(mk("lock2",  1,0,'h40,0,      0,0,0,0,         1, 0,0,0,'h5,  0,0,'hAAAA,'hBBBB,0));
    tbl.push_back(mk("lock3",  1,0,'h40,0,      1,0,'h5,0,       0, 1,0,0,'h5,  0,0,'hAAAA,'hBBBB,0));
    tbl.push_back(mk("lock4",  0,0,0,0,         1,0,'h5,0,       0, 0,1,0,'h40, 0,0,'hAAAA,'hBBBB,1));
    tbl.push_back(mk("lock5",  0,0,0,0,         0,0,0,0,         0, 0,0,0,'h5,  1,0,'h1040,'hBBBB,1));
    tbl.push_back(mk("lock6",  0,0,0,0,         0,0,0,0,         0, 0,0,0,'h5,  0,1,'h1040,'h1234,1));
    tbl.push_back(mk("nolk0",  1,1,'h50,'h5555, 0,0,0,0,         1, 1,0,0,'h5,  0,0,'h1040,'h1234,0));
    tbl.push_back(mk("nolk1",  1,1,'h52,'h7777, 0,0,0,0,         1, 1,0,1,'h50, 0,0,'h1040,'h1234,0));
    tbl.push_back(mk("nolk2",  0,0,0,0,         0,0,0,0,         0, 0,0,1,'h52, 0,0,'h1040,'h1234,0));

    drive(mk("rst", 1,1,'h77,'h9999, 1,1,'h78,'h8888, 1, 0,0,0,0, 0,0,0,0,0));
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("rst.gnt0",   16'(b0.gnt),    16'h0);
    chk("rst.gnt1",   16'(b1.gnt),    16'h0);
    chk("rst.wren",   16'(wren_ram),  16'h0);
    chk("rst.addr",   address_ram,    16'h0);
    chk("rst.data",   data_ram,       16'h0);
    chk("rst.rvalid", 16'({b0.rvalid, b1.rvalid}), 16'h0);
    chk("rst.rdata0", b0.rdata,       16'h0);
    chk("rst.rdata1", b1.rdata,       16'h0);
    chk("rst.busy",   16'(busy),      16'h0);

    @(negedge clock);
    drive(mk("rel", 0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0,0,0,0));
    reset_n = 1'b1;

    foreach (tbl[i])
      run_vec(tbl[i]);

    // Read granted, then reset lands while it is in flight.
    @(negedge clock);
    b0.req = 1'b1; b0.we = 1'b0; b0.addr = 16'h10;
    #1;
    chk("mid.gnt0", 16'(b0.gnt), 16'h1);
    @(negedge clock);
    b0.req = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid.rst.busy", 16'(busy), 16'h0);
    chk("mid.rst.rdata0", b0.rdata, 16'h0);
    chk("mid.rst.addr", address_ram, 16'h0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      chk($sformatf("mid.post%0d.rvalid0", i), 16'(b0.rvalid), 16'h0);
      chk($sformatf("mid.post%0d.wren", i),    16'(wren_ram),  16'h0);
      chk($sformatf("mid.post%0d.addr", i),    address_ram,    16'h0);
    end

    @(negedge clock);
    b0.req = 1'b1; b0.addr = 16'h3;
    #1;
    chk("mid.again.gnt0", 16'(b0.gnt), 16'h1);
    @(negedge clock);
    b0.req = 1'b0;
    #1;
    chk("mid.again.addr", address_ram, 16'h3);
    @(negedge clock);
    #1;
    chk("mid.again.rvalid0", 16'(b0.rvalid), 16'h1);
    chk("mid.again.rdata0",  b0.rdata,       16'h1003);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
